serial_alu_ctrl: RTL and testbench
==================================

# serial_alu_ctrl

Bit-serial sequencer for the 1-bit ALU slice. It latches two WIDTH-bit operands and an opcode on a start request, then drives the external slice one bit per clock, LSB first. It carries the slice's carry-out back into its carry-in and shifts each result bit into a result register. The block sits between the register file/bus and a single ALU slice, so one slice serves a full word.

## Interface
- WIDTH, 8, operand/result width in bits (≥2).
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  request; sampled only in IDLE.
- op  in  3  opcode: 0 plus, 1 AND, 2 OR, 3 XOR, 4 XNOR, 5–7 illegal.
- a  in  WIDTH  operand A; latched on accepted start.
- b  in  WIDTH  operand B; latched on accepted start.
- cin  in  1  carry-in for plus; latched on accepted start.
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle completion pulse.
- err  out  1  illegal opcode flag; valid with done, held until next accepted start.
- result  out  WIDTH  result word; held until next accepted start.
- cout  out  1  final carry for plus; 0 for all other ops.
- alu_m  out  3  opcode to slice (latched op).
- alu_a  out  1  current A bit to slice.
- alu_b  out  1  current B bit to slice.
- alu_ci  out  1  carry into slice.
- alu_x  in  1  slice result bit (combinational from alu_* outputs).
- alu_co  in  1  slice carry-out.

## Operation
- States: IDLE, RUN, DONE. The state is a register; the bit counter is ceil(log2(WIDTH)) bits wide.
- **IDLE**
  - start=1 with op≤4: latch a, b, op.
  - Load the carry register with cin when op=0, otherwise with 0.
  - Clear the bit counter, clear err, go to RUN.
- **Illegal start** (IDLE, start=1, op≥5): latch op, set err=1, clear result to 0, clear cout to 0, go to DONE without entering RUN.
- **RUN**
  - Drive alu_a=A_reg[cnt], alu_b=B_reg[cnt], alu_ci=carry_reg, alu_m=op_reg.
  - Each edge: result <= {alu_x, result[WIDTH-1:1]}, carry_reg <= alu_co, cnt <= cnt+1.
  - When cnt=WIDTH-1 the last bit is captured; go to DONE.
- **DONE**
  - done=1 for exactly one cycle.
  - cout = carry_reg when op_reg=0, else 0. The registered value is held until the next accepted start.
  - Go to IDLE unconditionally; start during DONE is ignored.
- Outside RUN: alu_a=0, alu_b=0, alu_ci=0; alu_m holds op_reg.
- Arithmetic: plus is modulo 2^WIDTH; the carry out of bit WIDTH-1 appears on cout. Logic ops ignore carry; the slice forces its own carry internally.
- Operands and cin are latched, so input changes during RUN/DONE have no effect.
- start while busy is ignored; nothing is queued.

## Timing
- Reset values: busy=0, done=0, err=0, result=0, cout=0, alu_a=0, alu_b=0, alu_ci=0, alu_m=0, state=IDLE.
- Valid start sampled at edge k:
  - busy=1 for cycles k+1 … k+WIDTH.
  - done=1 in cycle k+WIDTH+1.
  - First start accepted again at edge k+WIDTH+2.
- Illegal op sampled at edge k: busy stays 0; done=1 and err=1 in cycle k+1.
- result and cout are stable and valid in the done cycle, and remain valid until the next accepted start edge.
- rst during RUN or DONE: at the next edge all outputs return to reset values and state=IDLE. A start on the same edge as rst is ignored.
- Slice path is combinational (alu_a/alu_b/alu_ci → alu_x/alu_co) within one cycle. No other combinational input-to-output path.

## Test plan
- WIDTH=8, plus, a=0x5A, b=0x3C, cin=0 → busy 8 cycles, then done with result=0x96, cout=0, err=0.
- Plus, a=0xFF, b=0x01, cin=0 → result=0x00, cout=1; done exactly 9 cycles after the start edge.
- AND 0xF0,0x3C → 0x30, cout=0. XNOR 0xA5,0x0F → 0x55, cout=0. OR 0x81,0x18 → 0x99.
- op=5, a=0x12 → done and err=1 one cycle after start, busy never high, result=0x00.
- Plus 0x01+0x01: change a/b to 0xFF mid-run and pulse start at busy cycle 3 → result=0x02, no second operation.
- Assert rst at busy cycle 4 of a plus → next cycle busy=0, done=0, result=0, cout=0. A new start afterward completes normally.

Source files
------------

// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: bit-serial sequencer that drives a single 1-bit ALU slice
// LSB first, feeding the slice carry back and shifting results into a word.
module serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic [2:0]       alu_m,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_ci,
  input  logic             alu_x,
  input  logic             alu_co
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [2:0] OP_PLUS = 3'd0;
  localparam logic [2:0] OP_MAX  = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [2:0]       op_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] result_reg;
  logic             cout_reg;
  logic             err_reg;

  logic op_legal;
  assign op_legal = (op <= OP_MAX);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: illegal opcodes skip straight to DONE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = op_legal ? RUN : DONE;
        end
      end
      RUN: begin
        if (cnt_reg == LAST_BIT) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands on accepted start, then shift one bit per clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
      result_reg <= '0;
      cout_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_reg     <= op;
            result_reg <= '0;
            cout_reg   <= 1'b0;
            if (op_legal) begin
              a_reg     <= a;
              b_reg     <= b;
              carry_reg <= (op == OP_PLUS) ? cin : 1'b0;
              cnt_reg   <= '0;
              err_reg   <= 1'b0;
            end else begin
              err_reg   <= 1'b1;
            end
          end
        end
        RUN: begin
          result_reg <= {alu_x, result_reg[WIDTH-1:1]};
          carry_reg  <= alu_co;
          cnt_reg    <= cnt_reg + 1'b1;
          // The final carry is captured on the last bit so it is valid in DONE.
          if (cnt_reg == LAST_BIT) begin
            cout_reg <= (op_reg == OP_PLUS) ? alu_co : 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state_reg == RUN);
  assign done   = (state_reg == DONE);
  assign err    = err_reg;
  assign result = result_reg;
  assign cout   = cout_reg;
  assign alu_m  = op_reg;
  assign alu_a  = busy ? a_reg[cnt_reg] : 1'b0;
  assign alu_b  = busy ? b_reg[cnt_reg] : 1'b0;
  assign alu_ci = busy ? carry_reg : 1'b0;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Testbench for serial_alu_ctrl: behavioural slice model plus word-level
// reference model, directed and random transactions.
module tb_serial_alu_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] result;
  logic         cout;
  logic [2:0]   alu_m;
  logic         alu_a;
  logic         alu_b;
  logic         alu_ci;
  logic         alu_x;
  logic         alu_co;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .err(err), .result(result), .cout(cout),
    .alu_m(alu_m), .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci),
    .alu_x(alu_x), .alu_co(alu_co)
  );

  // 1-bit ALU slice: full adder for plus, plain gates for logic ops.
  always_comb begin
    alu_x  = 1'b0;
    alu_co = 1'b0;
    case (alu_m)
      3'd0: begin
        alu_x  = alu_a ^ alu_b ^ alu_ci;
        alu_co = (alu_a & alu_b) | (alu_a & alu_ci) | (alu_b & alu_ci);
      end
      3'd1: alu_x = alu_a & alu_b;
      3'd2: alu_x = alu_a | alu_b;
      3'd3: alu_x = alu_a ^ alu_b;
      3'd4: alu_x = ~(alu_a ^ alu_b);
      default: ;
    endcase
  end

  // Word-level reference: returns {err, cout, result}.
  function automatic logic [W+1:0] model(input logic [2:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y, input logic c);
    logic [W:0] s;
    s = '0;
    case (o)
      3'd0: begin
        s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        return {1'b0, s};
      end
      3'd1: return {2'b00, x & y};
      3'd2: return {2'b00, x | y};
      3'd3: return {2'b00, x ^ y};
      3'd4: return {2'b00, ~(x ^ y)};
      default: return {1'b1, 1'b0, {W{1'b0}}};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; optional scrambling of inputs while busy/done.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic c, input bit scramble);
    logic [W+1:0] exp;
    exp = model(o, x, y, c);
    op = o; a = x; b = y; cin = c; start = 1'b1;
    tick();
    start = 1'b0;
    if (o > 3'd4) begin
      check({tag, "_ill_done"}, done, 1);
      check({tag, "_ill_err"}, err, 1);
      check({tag, "_ill_busy"}, busy, 0);
      check({tag, "_ill_result"}, result, 0);
      check({tag, "_ill_cout"}, cout, 0);
      check({tag, "_ill_alu_m"}, alu_m, o);
      tick();
      check({tag, "_ill_after_done"}, done, 0);
      check({tag, "_ill_after_busy"}, busy, 0);
      check({tag, "_ill_err_held"}, err, 1);
      $display("[TB] %s op=%0d a=0x%02h -> err=%0b result=0x%02h", tag, o, x, err, result);
      return;
    end
    for (int i = 0; i < W; i++) begin
      check({tag, "_busy"}, busy, 1);
      check({tag, "_no_done"}, done, 0);
      check({tag, "_alu_m"}, alu_m, o);
      check({tag, "_alu_a"}, alu_a, x[i]);
      check({tag, "_alu_b"}, alu_b, y[i]);
      if (scramble) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        op = 3'($urandom); start = 1'($urandom);
      end
      tick();
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_done_busy"}, busy, 0);
    check({tag, "_result"}, result, exp[W-1:0]);
    check({tag, "_cout"}, cout, exp[W]);
    check({tag, "_err"}, err, exp[W+1]);
    check({tag, "_idle_alu_a"}, alu_a, 0);
    start = 1'b0;
    tick();
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_result_held"}, result, exp[W-1:0]);
    check({tag, "_cout_held"}, cout, exp[W]);
    $display("[TB] %s op=%0d a=0x%02h b=0x%02h cin=%0b -> result=0x%02h cout=%0b err=%0b",
             tag, o, x, y, c, result, cout, err);
  endtask

  initial begin
    logic [W+1:0] exp;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_result", result, 0);
    check("rst_cout", cout, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_ci", alu_ci, 0);
    check("rst_alu_m", alu_m, 0);
    rst = 1'b0;
    tick();
    $display("[TB] reset checked");

    // Directed vectors.
    run_op("plus_5a_3c", 3'd0, 8'h5A, 8'h3C, 1'b0, 1'b0);
    run_op("plus_ff_01", 3'd0, 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op("and_f0_3c",  3'd1, 8'hF0, 8'h3C, 1'b1, 1'b0);
    run_op("xnor_a5_0f", 3'd4, 8'hA5, 8'h0F, 1'b0, 1'b0);
    run_op("or_81_18",   3'd2, 8'h81, 8'h18, 1'b0, 1'b0);
    run_op("xor_ff_0f",  3'd3, 8'hFF, 8'h0F, 1'b0, 1'b0);
    run_op("plus_cin",   3'd0, 8'hFF, 8'hFF, 1'b1, 1'b0);
    run_op("illegal_5",  3'd5, 8'h12, 8'h34, 1'b0, 1'b0);
    run_op("plus_after_ill", 3'd0, 8'h10, 8'h20, 1'b0, 1'b0);

    // Mid-run input change and start pulse at busy cycle 3.
    op = 3'd0; a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("mid_busy3", busy, 1);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 20 && !done; n++) tick();
    check("mid_done", done, 1);
    check("mid_result", result, 8'h02);
    check("mid_cout", cout, 0);
    for (int n = 0; n < 4; n++) begin
      tick();
      check("mid_no_second", busy, 0);
    end
    $display("[TB] midrun change -> result=0x%02h", result);

    // Reset during RUN, with a simultaneous start.
    op = 3'd0; a = 8'h33; b = 8'h44; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("rst_mid_busy4", busy, 1);
    rst = 1'b1; start = 1'b1;
    tick();
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_result", result, 0);
    check("rst_mid_cout", cout, 0);
    check("rst_mid_err", err, 0);
    check("rst_mid_alu_m", alu_m, 0);
    rst = 1'b0; start = 1'b0;
    tick();
    check("rst_start_ignored", busy, 0);
    $display("[TB] reset mid-run checked");
    run_op("plus_after_rst", 3'd0, 8'h33, 8'h44, 1'b1, 1'b0);

    // Random transactions, with input scrambling while busy.
    for (int t = 0; t < 24; t++) begin
      run_op($sformatf("rand%0d", t), 3'($urandom_range(0, 7)), W'($urandom),
             W'($urandom), 1'($urandom), 1'($urandom));
    end

    exp = model(3'd0, 8'h5A, 8'h3C, 1'b0);
    check("model_sanity_plus", {23'd0, exp}, {23'd0, 2'b00, 8'h96});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
